// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Owns the fetch PC and runs a request/response handshake with instruction
// memory. One fetch is in flight at a time. A returned word waits in a
// one-entry buffer until decode accepts it into the IF/ID register.
// Redirects (branch/jump) retarget the fetch PC. A response that was already
// in flight when the redirect arrived is marked for discard, so a wrong-path
// word never reaches IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PC_WriteEnable,
  input  logic        IFIDWriteEnable,
  input  logic        IFIDFlush,
  input  logic        Branch,
  input  logic [31:0] BranchDest,
  input  logic        Jump,
  input  logic [31:0] JumpDest,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {
    ST_REQ,   // ready to issue a request for fetch_pc
    ST_WAIT,  // request accepted, response outstanding
    ST_FULL   // fetch_buf holds the word at fetch_pc
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_buf;
  logic        discard;   // the outstanding response belongs to a squashed path

  logic        redirect;
  logic [31:0] target;
  logic        accept;
  logic        consume;

  // Branch wins when both redirect sources fire in the same cycle.
  assign redirect = Branch | Jump;
  assign target   = Branch ? BranchDest : JumpDest;

  assign IMemReq  = (state == ST_REQ) & PC_WriteEnable & ~Reset;
  assign IMemAddr = fetch_pc;
  assign accept   = IMemReq & IMemReady;

  // The buffered word moves into IF/ID only when decode takes it and no
  // redirect has made it stale.
  assign consume  = (state == ST_FULL) & IFIDWriteEnable & ~IFIDFlush & ~redirect;

  // Fetch control: state, fetch PC, buffer and discard tracking.
  always_ff @(posedge Clock) begin
    // NOTE: every register here uses <= so all branches see the pre-edge
    // values of state, fetch_pc and discard, whatever order they are written in.
    if (Reset) begin
      state     <= ST_REQ;
      fetch_pc  <= RESET_PC;
      fetch_buf <= '0;
      discard   <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (accept) begin
            state   <= ST_WAIT;
            // A redirect in the accept cycle makes the request just issued stale.
            discard <= redirect;
          end
          if (redirect) fetch_pc <= target;
        end

        ST_WAIT: begin
          if (IMemValid) begin
            discard <= 1'b0;
            if (!discard && !redirect) begin
              fetch_buf <= IMemData;
              state     <= ST_FULL;
            end else begin
              state <= ST_REQ;
            end
            // A redirect that arrives together with a dropped response still
            // has to take effect. Otherwise the wrong path would be fetched.
            if (redirect) fetch_pc <= target;
          end else if (redirect) begin
            discard  <= 1'b1;
            fetch_pc <= target;
          end
        end

        ST_FULL: begin
          if (redirect) begin
            state    <= ST_REQ;
            fetch_pc <= target;
          end else if (consume) begin
            state    <= ST_REQ;
            fetch_pc <= fetch_pc + 32'd4;
          end
        end

        default: state <= ST_REQ;
      endcase
    end
  end

  // IF/ID pipeline register. Flush beats write-enable. Bubbles carry the
  // current fetch PC.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Instruction <= NOP;
      PC          <= '0;
    end else if (IFIDFlush) begin
      Instruction <= NOP;
      PC          <= fetch_pc;
    end else if (consume) begin
      Instruction <= fetch_buf;
      PC          <= fetch_pc;
    end else if (IFIDWriteEnable) begin
      Instruction <= NOP;
      PC          <= fetch_pc;
    end
  end

endmodule
